booth_sign_frontend: RTL and testbench

//  Operand/result wrapper around the Booth multiplier core. Accepts signed two's-complement

---
 rtl/booth_sign_frontend.sv | 162 ++++++++++++++++
 tb/tb_booth_sign_frontend.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_sign_frontend.sv
// booth_sign_frontend
// Signed operand/result wrapper around an unsigned Booth multiplier core.
// It takes a signed operand pair and hands the core the two magnitudes, the
// product sign and a one-cycle start pulse. When the core reports done, it
// applies the sign to the magnitude product and offers the signed 2W-bit
// result downstream. It also flags a result outside the signed W-bit range,
// and a core that never answers.
//
// Handshakes: a transfer happens on the rising clock edge where valid and
// ready are both high. valid, once raised, holds with its payload stable
// until that edge. ready may depend on state only, never on valid.
module booth_sign_frontend #(
    parameter int WORD_LENGTH    = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_LENGTH-1:0]     in_multiplicand,
    input  logic [WORD_LENGTH-1:0]     in_multiplier,
    output logic                       mul_start,
    output logic [WORD_LENGTH-1:0]     mul_multiplicand,
    output logic [WORD_LENGTH-1:0]     mul_multiplier,
    output logic                       mul_sign,
    input  logic                       mul_ready,
    input  logic [2*WORD_LENGTH-1:0]   mul_product,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WORD_LENGTH-1:0]   out_result,
    output logic                       out_overflow,
    output logic                       out_error
);

    localparam int W  = WORD_LENGTH;
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  COUNT_ONE  = CW'(1);
    localparam logic [W-1:0]   ONE_W      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_2W     = {{(2*W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_FIX   = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [CW-1:0]  count;
    logic [2*W-1:0] product_q;
    logic [2*W-1:0] fix_result;
    logic           fix_overflow;
    logic [W:0]     fix_top;

    // Magnitude in W bits unsigned; the most negative value maps onto 2^(W-1).
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
        return v[W-1] ? (~v + ONE_W) : v;
    endfunction

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; in WAIT a done from the core beats the timeout.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid) state_next = S_LOAD;
            S_LOAD:  state_next = S_START;
            S_START: state_next = S_WAIT;
            S_WAIT: begin
                if (mul_ready) begin
                    state_next = S_FIX;
                end else if (count == COUNT_LAST) begin
                    state_next = S_OUT;
                end
            end
            S_FIX:   state_next = S_OUT;
            S_OUT:   if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake and strobe outputs decoded purely from state.
    always_comb begin
        in_ready  = (state == S_IDLE);
        mul_start = (state == S_START);
        out_valid = (state == S_OUT);
    end

    // Sign application and signed W-bit range check for the FIX step.
    // The result fits in W signed bits exactly when its top W+1 bits agree.
    always_comb begin
        fix_result   = mul_sign ? (~product_q + ONE_2W) : product_q;
        fix_top      = fix_result[2*W-1:W-1];
        fix_overflow = !((&fix_top) || !(|fix_top));
    end

    // Datapath registers: operand capture, core operands, timeout counter, result.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a             <= '0;
            op_b             <= '0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            mul_sign         <= 1'b0;
            count            <= '0;
            product_q        <= '0;
            out_result       <= '0;
            out_overflow     <= 1'b0;
            out_error        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_a <= in_multiplicand;
                        op_b <= in_multiplier;
                    end
                end
                S_LOAD: begin
                    mul_multiplicand <= magnitude(op_a);
                    mul_multiplier   <= magnitude(op_b);
                    // A zero operand gives a zero product, which is never negative.
                    mul_sign <= (op_a[W-1] ^ op_b[W-1]) && (op_a != '0) && (op_b != '0);
                end
                S_START: begin
                    count <= '0;
                end
                S_WAIT: begin
                    count <= count + COUNT_ONE;
                    if (mul_ready) begin
                        product_q <= mul_product;
                    end else if (count == COUNT_LAST) begin
                        out_result   <= '0;
                        out_overflow <= 1'b0;
                        out_error    <= 1'b1;
                    end
                end
                S_FIX: begin
                    out_result   <= fix_result;
                    out_overflow <= fix_overflow;
                    out_error    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_sign_frontend.sv
// tb_booth_sign_frontend
// Directed vectors for booth_sign_frontend with a behavioural core model,
// an expected-result queue and a monitor that checks every offered result.
module tb_booth_sign_frontend;

    localparam int W = 16;
    localparam int T = 20;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_multiplicand;
    logic [W-1:0]    in_multiplier;
    logic            mul_start;
    logic [W-1:0]    mul_multiplicand;
    logic [W-1:0]    mul_multiplier;
    logic            mul_sign;
    logic            mul_ready;
    logic [2*W-1:0]  mul_product;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out_result;
    logic            out_overflow;
    logic            out_error;

    // Expected result entries: {result, overflow, error}
    logic [2*W+1:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int valid_cyc = 0;
    logic prev_valid = 1'b0;

    // Core model configuration, set by the driver before each operation
    int          core_dly  = 0;   // 0 = core never answers
    logic [2*W-1:0] core_prod = '0;
    logic [W-1:0] exp_mc   = '0;
    logic [W-1:0] exp_mp   = '0;
    logic         exp_sign = 1'b0;
    logic         expect_drop = 1'b0;

    booth_sign_frontend #(
        .WORD_LENGTH    (W),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_multiplicand  (in_multiplicand),
        .in_multiplier    (in_multiplier),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_sign         (mul_sign),
        .mul_ready        (mul_ready),
        .mul_product      (mul_product),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_overflow     (out_overflow),
        .out_error        (out_error)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Core model: checks the operands at the start pulse, then answers after core_dly cycles
    initial begin
        mul_ready   = 1'b0;
        mul_product = '0;
        forever begin
            @(negedge clk);
            if (mul_start === 1'b1) begin
                start_cyc = cyc;
                check("core_multiplicand", 64'(mul_multiplicand), 64'(exp_mc));
                check("core_multiplier", 64'(mul_multiplier), 64'(exp_mp));
                check("core_sign", 64'(mul_sign), 64'(exp_sign));
                @(negedge clk);
                check("start_one_cycle", 64'(mul_start), 64'd0);
                if (core_dly >= 1) begin
                    repeat (core_dly - 1) @(negedge clk);
                    if (!expect_drop) begin
                        check("core_operand_hold", 64'({mul_multiplicand, mul_multiplier}),
                              64'({exp_mc, exp_mp}));
                    end
                    mul_ready   = 1'b1;
                    mul_product = core_prod;
                    @(negedge clk);
                    mul_ready   = 1'b0;
                    mul_product = 32'($urandom);
                end
            end
        end
    end

    // Monitor: every cycle a result is offered it must match the queue head
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (prev_valid !== 1'b1) valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 64'd1, 64'd0);
                end else begin
                    check("out_result", 64'(out_result), 64'(exp_q[0][2*W+1:2]));
                    check("out_overflow", 64'(out_overflow), 64'(exp_q[0][1]));
                    check("out_error", 64'(out_error), 64'(exp_q[0][0]));
                    check("in_ready_busy", 64'(in_ready), 64'd0);
                    if (out_ready === 1'b1) void'(exp_q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    // Issue one operand pair; the expectation is queued unless the op is to be dropped
    task automatic issue_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] prod, input int dly,
                            input logic [W-1:0] emc, input logic [W-1:0] emp, input logic esign,
                            input logic [2*W-1:0] eres, input logic eovf, input logic eerr,
                            input logic push);
        bit seen = 0;
        core_prod = prod;
        core_dly  = dly;
        exp_mc    = emc;
        exp_mp    = emp;
        exp_sign  = esign;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) seen = 1;
        end
        check("in_ready_wait", 64'(seen), 64'd1);
        if (push) exp_q.push_back({eres, eovf, eerr});
        @(posedge clk);
        #1;
        in_valid        = 1'b1;
        in_multiplicand = a;
        in_multiplier   = b;
        @(posedge clk);
        #1;
        in_valid        = 1'b0;
        in_multiplicand = 16'($urandom);
        in_multiplier   = 16'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("result_wait", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] prod, input int dly,
                          input logic [W-1:0] emc, input logic [W-1:0] emp, input logic esign,
                          input logic [2*W-1:0] eres, input logic eovf, input logic eerr);
        issue_op(a, b, prod, dly, emc, emp, esign, eres, eovf, eerr, 1'b1);
        wait_done();
    endtask

    // Main sequence
    initial begin
        bit seen;
        reset           = 1'b1;
        in_valid        = 1'b0;
        in_multiplicand = '0;
        in_multiplier   = '0;
        out_ready       = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_mul_start", 64'(mul_start), 64'd0);
        check("rst_core_ops", 64'({mul_multiplicand, mul_multiplier, mul_sign}), 64'd0);
        check("rst_outputs", 64'({out_result, out_overflow, out_error}), 64'd0);

        // -32760 * 2 = -65520
        run_op(16'h8008, 16'd2, 32'd65520, 3, 16'd32760, 16'd2, 1'b1, 32'hFFFF0010, 1'b1, 1'b0);
        // 100 * -3 = -300
        run_op(16'd100, 16'hFFFD, 32'd300, 1, 16'd100, 16'd3, 1'b1, 32'hFFFFFED4, 1'b0, 1'b0);
        // -32768 * -32768 = 2^30
        run_op(16'h8000, 16'h8000, 32'h40000000, 2, 16'h8000, 16'h8000, 1'b0, 32'h40000000, 1'b1, 1'b0);
        // 7 * -6 = -42
        run_op(16'd7, 16'hFFFA, 32'd42, 5, 16'd7, 16'd6, 1'b1, 32'hFFFFFFD6, 1'b0, 1'b0);
        // -32768 * 1 = -32768, the most negative value still in range
        run_op(16'h8000, 16'd1, 32'd32768, 1, 16'h8000, 16'd1, 1'b1, 32'hFFFF8000, 1'b0, 1'b0);
        // -32768 * -1 = +32768, one past the positive limit
        run_op(16'h8000, 16'hFFFF, 32'd32768, 1, 16'h8000, 16'd1, 1'b0, 32'h00008000, 1'b1, 1'b0);
        // 32767 * 32767
        run_op(16'h7FFF, 16'h7FFF, 32'h3FFF0001, 4, 16'h7FFF, 16'h7FFF, 1'b0, 32'h3FFF0001, 1'b1, 1'b0);

        // 0 * -5 with the result back-pressured for 5 cycles
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue_op(16'd0, 16'hFFFB, 32'd0, 2, 16'd0, 16'd5, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1;
        end
        check("hold_valid_wait", 64'(seen), 64'd1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done();

        // Core answers in the very cycle the timeout would fire: the answer wins
        run_op(16'd3, 16'd4, 32'd12, T, 16'd3, 16'd4, 1'b0, 32'd12, 1'b0, 1'b0);

        // Core never answers: error result after the start pulse plus T wait cycles
        run_op(16'd9, 16'hFFFF, 32'd0, 0, 16'd9, 16'd1, 1'b1, 32'd0, 1'b0, 1'b1);
        check("timeout_latency", 64'(valid_cyc - start_cyc), 64'(T + 1));
        // and the next op is normal
        run_op(16'hFFFF, 16'd1, 32'd1, 2, 16'd1, 16'd1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);

        // Reset in the middle of WAIT; the late core answer must be ignored
        expect_drop = 1'b1;
        issue_op(16'd5, 16'd6, 32'd30, 8, 16'd5, 16'd6, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_mul_start", 64'(mul_start), 64'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1;
        end
        check("midrst_no_output", 64'(seen), 64'd0);
        expect_drop = 1'b0;

        // Normal op after the reset
        run_op(16'hFFF6, 16'hFFF6, 32'd100, 3, 16'd10, 16'd10, 1'b0, 32'd100, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
